// File: rtl/zigbee_pkg.sv
// rtl/zigbee_pkg.sv - shared types and constants for the zigbee transmit controller
//
// Contents:
//   txState_t             transmit FSM state encoding
//   CHIPS_PER_SYMBOL_DEF  default chips emitted per 4-bit symbol
//   SYMBOL_WIDTH          bits per O-QPSK symbol
package zigbee_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    CODE  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5,
    ABORT = 3'd6
  } txState_t;

  localparam int CHIPS_PER_SYMBOL_DEF = 32;
  localparam int SYMBOL_WIDTH         = 4;

endpackage

// File: rtl/zigbee_tx_ctrl.sv
// rtl/zigbee_tx_ctrl.sv - frame sequencer feeding symbols from an input FIFO to the chip coder
//
// Optional feature macro: TX_CTRL_TIMEOUT_EN (empty-FIFO wait timeout with ABORT state)
//
// Ports:
//   inClock                     clock, rising edge
//   inReset                     synchronous active-low reset
//   inStart / inFrameLen        frame start request and symbol count
//   in_inFIFO_inEmpty/inData    input FIFO status and read data (data valid one cycle after pop)
//   out_inFIFO_outReadEnable    input FIFO pop
//   out_coder_outSymbol         symbol currently presented to the coder
//   out_coder_outEnable         coder advance, one chip per enabled cycle
//   in_outFIFO_inFull           output FIFO full flag
//   out_outFIFO_outWriteEnable  output FIFO write of the current chip
//   outBusy / outDone / outError  status: not idle, frame complete pulse, underrun abort pulse
//   outSymCount                 symbols fully coded in the current or last frame
module zigbee_tx_ctrl
  import zigbee_pkg::*;
#(
  parameter int CHIPS_PER_SYMBOL = CHIPS_PER_SYMBOL_DEF,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                    inClock,
  input  logic                    inReset,
  input  logic                    inStart,
  input  logic [7:0]              inFrameLen,
  input  logic                    in_inFIFO_inEmpty,
  input  logic [SYMBOL_WIDTH-1:0] in_inFIFO_inData,
  output logic                    out_inFIFO_outReadEnable,
  output logic [SYMBOL_WIDTH-1:0] out_coder_outSymbol,
  output logic                    out_coder_outEnable,
  input  logic                    in_outFIFO_inFull,
  output logic                    out_outFIFO_outWriteEnable,
  output logic                    outBusy,
  output logic                    outDone,
  output logic                    outError,
  output logic [7:0]              outSymCount
);

  localparam int                CHIP_W    = $clog2(CHIPS_PER_SYMBOL + 1);
  localparam logic [CHIP_W-1:0] LAST_CHIP = CHIP_W'(CHIPS_PER_SYMBOL - 1);

  txState_t          state;
  logic [CHIP_W-1:0] chipCount;
  logic [7:0]        frameLen;
  logic [7:0]        nextSymCount;
  logic              coderEnable;

  // Chips are produced combinationally from the enable, so the coder only
  // advances when the output FIFO can take the chip in the same cycle.
  assign coderEnable  = (state == CODE) && !in_outFIFO_inFull;
  assign nextSymCount = outSymCount + 8'd1;

  // Pop in the FETCH cycle itself; the data arrives while in LOAD.
  assign out_inFIFO_outReadEnable   = (state == FETCH) && !in_inFIFO_inEmpty;
  assign out_coder_outEnable        = coderEnable;
  assign out_outFIFO_outWriteEnable = coderEnable;
  assign outBusy                    = (state != IDLE);
  assign outDone                    = (state == DONE);

`ifdef TX_CTRL_TIMEOUT_EN
  localparam int              WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] waitCount;

  assign outError = (state == ABORT);
`else
  // Keeps the timeout parameter referenced when the feature is compiled out.
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT_CYCLES != 0);
  assign outError      = 1'b0;
`endif

  always_ff @(posedge inClock) begin
    if (!inReset) begin
      state               <= IDLE;
      chipCount           <= '0;
      frameLen            <= '0;
      outSymCount         <= '0;
      out_coder_outSymbol <= '0;
`ifdef TX_CTRL_TIMEOUT_EN
      waitCount           <= '0;
`endif
    end else begin
`ifdef TX_CTRL_TIMEOUT_EN
      // Only FETCH with an empty FIFO keeps the wait count alive.
      waitCount <= '0;
`endif
      unique case (state)
        IDLE: begin
          if (inStart) begin
            frameLen    <= inFrameLen;
            outSymCount <= '0;
            state       <= (inFrameLen == 8'd0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (!in_inFIFO_inEmpty) begin
            state <= LOAD;
          end
`ifdef TX_CTRL_TIMEOUT_EN
          else if (waitCount == WAIT_LAST) begin
            state <= ABORT;
          end else begin
            waitCount <= waitCount + 1'b1;
          end
`endif
        end
        LOAD: begin
          out_coder_outSymbol <= in_inFIFO_inData;
          chipCount           <= '0;
          state               <= CODE;
        end
        CODE: begin
          // A full output FIFO freezes both counter and state so no chip is lost.
          if (coderEnable) begin
            chipCount <= chipCount + 1'b1;
            if (chipCount == LAST_CHIP) begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          outSymCount <= nextSymCount;
          state       <= (nextSymCount == frameLen) ? DONE : FETCH;
        end
        DONE:    state <= IDLE;
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/zigbee_tx_ctrl.md
ZIGBEE_TX_CTRL -- requirements
Module: zigbee_tx_ctrl

Interface
REQ-001 The block SHALL have parameter CHIPS_PER_SYMBOL, default 32, meaning chips the coder emits per 4-bit symbol.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning maximum empty-FIFO wait before abort (used only with macro).
REQ-003 inClock  in  1  single clock; all logic on rising edge.
REQ-004 inReset  in  1  synchronous, active-low reset.
REQ-005 inStart  in  1  one-cycle frame start request.
REQ-006 inFrameLen  in  8  symbols in frame, sampled on accepted inStart.
REQ-007 in_inFIFO_inEmpty  in  1  input FIFO empty flag.
REQ-008 in_inFIFO_inData  in  4  input FIFO read data, valid one cycle after read enable.
REQ-009 out_inFIFO_outReadEnable  out  1  one-cycle input FIFO pop.
REQ-010 out_coder_outSymbol  out  4  registered symbol presented to coder.
REQ-011 out_coder_outEnable  out  1  coder advance; one chip per enabled cycle.
REQ-012 in_outFIFO_inFull  in  1  output FIFO full flag.
REQ-013 out_outFIFO_outWriteEnable  out  1  write coder chip to output FIFO.
REQ-014 outBusy  out  1  high in any state except IDLE.
REQ-015 outDone  out  1  one-cycle pulse on frame completion.
REQ-016 outError  out  1  one-cycle pulse on underrun abort.
REQ-017 outSymCount  out  8  symbols fully coded in current/last frame.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, LOAD, CODE, NEXT, DONE, ABORT.
REQ-019 IDLE: inStart=1 SHALL latch inFrameLen, clear outSymCount, go FETCH; inFrameLen=0 SHALL go directly DONE.
REQ-020 inStart while not IDLE SHALL be ignored.
REQ-021 FETCH: if in_inFIFO_inEmpty=0, assert out_inFIFO_outReadEnable one cycle and go LOAD; else stay.
REQ-022 LOAD: capture in_inFIFO_inData into out_coder_outSymbol, clear chip counter, go CODE.
REQ-023 CODE: out_coder_outEnable = (state==CODE) & !in_outFIFO_inFull (combinational); chip counter increments per enabled cycle.
REQ-024 out_outFIFO_outWriteEnable SHALL equal out_coder_outEnable in the same cycle (coder chip output is combinational to enable).
REQ-025 After CHIPS_PER_SYMBOL enabled cycles, go NEXT; full stalls hold counter and state without chip loss.
REQ-026 NEXT: increment outSymCount; if outSymCount+1==latched length go DONE else FETCH.
REQ-027 DONE: pulse outDone, go IDLE; outSymCount holds until next accepted inStart.
REQ-028 Chip counter width SHALL be clog2(CHIPS_PER_SYMBOL+1); outSymCount wraps never (bounded by 8-bit length).
REQ-029 Symbol latency: FETCH->first chip write = 2 cycles when FIFO non-empty and output not full.

Reset
REQ-030 inReset=0 at a rising edge SHALL force IDLE, all outputs 0, counters 0, latched length 0, including mid-frame.
REQ-031 Reset SHALL override inStart in the same cycle.

Configuration
REQ-032 With TX_CTRL_TIMEOUT_EN defined: a wait counter counts FETCH cycles with empty=1; reaching TIMEOUT_CYCLES SHALL go ABORT, pulse outError one cycle, then IDLE; counter clears on leaving FETCH.
REQ-033 Without TX_CTRL_TIMEOUT_EN: no wait counter, ABORT unreachable, outError tied 0, FETCH waits indefinitely.

Structure
REQ-034 Shared package zigbee_pkg SHALL hold the FSM state enum, CHIPS_PER_SYMBOL default and symbol width constant (4).
REQ-035 Single module, no sub-module; chip counter and FSM inline.

Verification
REQ-036 Length 3, FIFO holds 0x1,0x4,0x9, output never full -> reads at FETCH, symbols 1,4,9 on outSymbol, 96 write enables, outDone once, outSymCount=3.
REQ-037 Length 1, inFull high cycles 10-14 of CODE -> enable low exactly 5 cycles, 32 writes total, no chip dropped.
REQ-038 inFrameLen=0 start -> outDone one cycle after start, no read enable, outSymCount=0.
REQ-039 Start with FIFO empty 50 cycles then 0xD pushed -> no read during empty, symbol 0xD coded; with macro and TIMEOUT_CYCLES=255, 300 empty cycles -> outError pulse at cycle 255, IDLE.
REQ-040 inReset low mid-CODE of symbol 2 -> next cycle IDLE, all outputs 0; second inStart during busy -> ignored, single outDone.
